// File: rtl/ff_stream_sink.sv
// ff_stream_sink
//   Receiving end of a valid-only register-stage stream (no backpressure).
//   Every upstream beat is captured into a small FIFO and re-presented
//   downstream on a valid/ready handshake. Beats arriving while the FIFO is
//   full (and not being drained that cycle) are dropped, counted and flagged.
//
// Handshake: downstream transfer happens on a rising clk edge where
//   valid_o & ready_i. valid_o depends only on registered state, and data_o
//   stays stable while valid_o & ~ready_i. Upstream has no ready; valid_i is
//   sampled every cycle.
//
// Ports
//   clk         in   clock, posedge
//   reset       in   synchronous, active-high; overrides all other inputs
//   valid_i     in   upstream beat present
//   data_i      in   [SIZE-1:0] upstream data
//   data_o      out  [SIZE-1:0] head-of-FIFO data
//   valid_o     out  FIFO non-empty
//   ready_i     in   downstream accepts
//   count_o     out  [CW-1:0] occupancy 0..DEPTH
//   full_o      out  count_o == DEPTH
//   overflow_o  out  sticky drop flag
//   drop_cnt_o  out  [15:0] saturating dropped-beat counter
//   clear_i     in   clears overflow_o and drop_cnt_o only
module ff_stream_sink #(
    parameter int SIZE  = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  logic [SIZE-1:0] data_i,
    output logic [SIZE-1:0] data_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [CW-1:0]   count_o,
    output logic            full_o,
    output logic            overflow_o,
    output logic [15:0]     drop_cnt_o,
    input  logic            clear_i
);

    localparam int AW = $clog2(DEPTH);

    logic [SIZE-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overflow;
    logic [15:0]     r_drop_cnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // A full FIFO still accepts a beat when the head leaves in the same cycle.
    assign w_pop  = ~w_empty & ready_i;
    assign w_push = valid_i & (~w_full | w_pop);
    assign w_drop = valid_i & w_full & ~w_pop;

    // Storage and pointers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Drop bookkeeping; clear takes priority over a same-cycle drop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign data_o     = r_mem[r_rd_ptr];
    assign valid_o    = ~w_empty;
    assign full_o     = w_full;
    assign count_o    = r_count;
    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;

endmodule

// File: tb/tb_ff_stream_sink.sv
module tb_ff_stream_sink;

    localparam int SIZE  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            valid_i = 1'b0;
    logic [SIZE-1:0] data_i = '0;
    logic            ready_i = 1'b0;
    logic            clear_i = 1'b0;
    logic [SIZE-1:0] data_o;
    logic            valid_o;
    logic [CW-1:0]   count_o;
    logic            full_o;
    logic            overflow_o;
    logic [15:0]     drop_cnt_o;

    always #5 clk = ~clk;

    ff_stream_sink #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .full_o     (full_o),
        .overflow_o (overflow_o),
        .drop_cnt_o (drop_cnt_o),
        .clear_i    (clear_i)
    );

    // ---------------- scoreboard ----------------
    logic [SIZE-1:0] exp_q[$];
    int              m_count;
    logic            m_ovf;
    logic [15:0]     m_drop;
    int              n_checks = 0;
    int              n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive on negedge, check the head on a pop, advance the
    // reference model, then compare registered outputs just after posedge.
    task automatic step(input logic v, input logic [SIZE-1:0] d, input logic r,
                        input logic c, input logic rst);
        logic pop, push, drop, full;
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clear_i = c;
        reset   = rst;
        if (rst) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
            m_drop  = '0;
        end else begin
            full = (m_count == DEPTH);
            pop  = (m_count != 0) && r;
            push = v && (!full || pop);
            drop = v && full && !pop;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("pop_underflow", 32'd1, 32'd0);
                end else begin
                    check("pop_data", data_o, exp_q.pop_front());
                end
            end
            if (push) exp_q.push_back(d);
            m_count = m_count + (push ? 1 : 0) - (pop ? 1 : 0);
            if (c) begin
                m_ovf  = 1'b0;
                m_drop = '0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        check("count", 32'(count_o), 32'(m_count));
        check("valid", 32'(valid_o), 32'(m_count != 0));
        check("full", 32'(full_o), 32'(m_count == DEPTH));
        check("overflow", 32'(overflow_o), 32'(m_ovf));
        check("drop_cnt", 32'(drop_cnt_o), 32'(m_drop));
        if (m_count != 0 && exp_q.size() != 0) check("head", data_o, exp_q[0]);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            v;
        logic [SIZE-1:0] d;
        logic            r;
        logic            c;
        int              e_count;
        logic            e_valid;
        logic            e_full;
        logic            e_ovf;
        logic [15:0]     e_drop;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // single beat in and out
        vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 16'd0};
        // fill, overflow by two, drain
        vecs[2]  = '{1'b1, 32'h10, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 32'h11, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b1, 32'h12, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b1, 32'h13, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b0, 16'd0};
        vecs[6]  = '{1'b1, 32'h14, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 16'd1};
        vecs[7]  = '{1'b1, 32'h15, 1'b0, 1'b0, 4, 1'b1, 1'b1, 1'b1, 16'd2};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[9]  = '{1'b0, 32'h0,  1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[11] = '{1'b0, 32'h0,  1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1, 16'd2};
        // empty with ready and valid: no pop, count goes 0 -> 1
        vecs[12] = '{1'b1, 32'h5A, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b1, 16'd2};

        // ---------------- reset ----------------
        m_count = 0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("reset_data", data_o, 32'h0);

        // ---------------- table ----------------
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].r, vecs[i].c, 1'b0);
            check($sformatf("tbl%0d_count", i), 32'(count_o), 32'(vecs[i].e_count));
            check($sformatf("tbl%0d_valid", i), 32'(valid_o), 32'(vecs[i].e_valid));
            check($sformatf("tbl%0d_full", i), 32'(full_o), 32'(vecs[i].e_full));
            check($sformatf("tbl%0d_ovf", i), 32'(overflow_o), 32'(vecs[i].e_ovf));
            check($sformatf("tbl%0d_drop", i), 32'(drop_cnt_o), 32'(vecs[i].e_drop));
        end
        check("tbl_head_5a", data_o, 32'h5A);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // ---------------- full with simultaneous push/pop, pointer wrap ----------------
        for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h20 + 32'(i), 1'b1, 1'b0, 1'b0);
            check("wrap_count", 32'(count_o), 32'd4);
        end
        check("wrap_no_drop", 32'(drop_cnt_o), 32'd2);
        check("wrap_head", data_o, 32'h24);

        // ---------------- clear in the same cycle as a drop ----------------
        step(1'b1, 32'h99, 1'b0, 1'b1, 1'b0);
        check("clr_ovf", 32'(overflow_o), 32'd0);
        check("clr_drop", 32'(drop_cnt_o), 32'd0);
        check("clr_count", 32'(count_o), 32'd4);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // ---------------- random mixed traffic ----------------
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0), 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b1, 1'b0);

        // ---------------- drop counter saturation ----------------
        for (int i = 0; i < 4; i++) step(1'b1, 32'h40 + 32'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65534; i++) step(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        check("sat_fffe", 32'(drop_cnt_o), 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b0);
        check("sat_ffff", 32'(drop_cnt_o), 32'h0000_FFFF);
        check("sat_ovf", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // ---------------- reset mid-stream ----------------
        for (int i = 0; i < 3; i++) step(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h66, 1'b0, 1'b0, 1'b1);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_drop", 32'(drop_cnt_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_data", data_o, 32'h0);
        step(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
        check("post_rst_count", 32'(count_o), 32'd1);
        check("post_rst_data", data_o, 32'h77);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
